// File: rtl/alu_seq_unit.sv
// Iterative MUL/DIV/MOD engine: a shift-add multiplier and a restoring divider, one bit per cycle.
// Define ALU_SEQ_DBZ_FAST_EN to finish divide-by-zero in the cycle right after start.
module alu_seq_unit #(
    parameter int         WIDTH  = 16,
    parameter logic [4:0] OP_MUL = 5'd7,
    parameter logic [4:0] OP_DIV = 5'd2,
    parameter logic [4:0] OP_MOD = 5'd5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             done_mul,
    output logic             done_div,
    output logic             done_mod,
    output logic             busy,
    output logic             mul_ovf,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {K_MUL, K_DIV, K_MOD} kind_t;

    state_t             state_q, state_d;
    kind_t              kind_q, kind_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_mul_q, done_mul_d;
    logic               done_div_q, done_div_d;
    logic               done_mod_q, done_mod_d;
    logic               busy_q, busy_d;
    logic               mul_ovf_q, mul_ovf_d;
    logic               dbz_q, dbz_d;

    logic               is_mul, is_div, is_mod;
    logic [2*WIDTH-1:0] mul_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   diff;
    logic               sub_ok;
    logic [WIDTH:0]     rem_next;
    logic [WIDTH-1:0]   quo_next;

    always_comb begin
        is_mul = (alu_op == OP_MUL);
        is_div = (alu_op == OP_DIV);
        is_mod = (alu_op == OP_MOD);

        // One step of each algorithm; only the one matching the latched op is committed.
        mul_sum  = prod_q + (b_q[0] ? mcand_q : '0);
        shifted  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        diff     = {1'b0, shifted} - {2'b00, b_q};
        sub_ok   = ~diff[WIDTH+1];
        rem_next = sub_ok ? diff[WIDTH:0] : shifted;
        quo_next = {quo_q[WIDTH-2:0], sub_ok};

        state_d    = state_q;
        kind_d     = kind_q;
        cnt_d      = cnt_q;
        prod_d     = prod_q;
        mcand_d    = mcand_q;
        b_d        = b_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        result_d   = result_q;
        done_mul_d = 1'b0;
        done_div_d = 1'b0;
        done_mod_d = 1'b0;
        busy_d     = busy_q;
        mul_ovf_d  = mul_ovf_q;
        dbz_d      = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start && (is_mul || is_div || is_mod)) begin
                    kind_d    = is_mul ? K_MUL : (is_div ? K_DIV : K_MOD);
                    mcand_d   = {{WIDTH{1'b0}}, operand_a};
                    b_d       = operand_b;
                    prod_d    = '0;
                    rem_d     = '0;
                    quo_d     = operand_a;
                    cnt_d     = '0;
                    mul_ovf_d = 1'b0;
                    dbz_d     = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_RUN;
`ifdef ALU_SEQ_DBZ_FAST_EN
                    if (!is_mul && (operand_b == '0)) begin
                        state_d    = S_DONE;
                        dbz_d      = 1'b1;
                        result_d   = is_div ? '1 : operand_a;
                        done_div_d = is_div;
                        done_mod_d = is_mod;
                    end
`endif
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (kind_q == K_MUL) begin
                    prod_d  = mul_sum;
                    mcand_d = mcand_q << 1;
                    b_d     = b_q >> 1;
                end else begin
                    rem_d = rem_next;
                    quo_d = quo_next;
                end
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    // A zero divisor makes every trial subtraction succeed, so the quotient
                    // fills with ones and the remainder collects the dividend unchanged.
                    case (kind_q)
                        K_MUL: begin
                            result_d   = mul_sum[WIDTH-1:0];
                            mul_ovf_d  = |mul_sum[2*WIDTH-1:WIDTH];
                            done_mul_d = 1'b1;
                        end
                        K_DIV: begin
                            result_d   = quo_next;
                            dbz_d      = (b_q == '0);
                            done_div_d = 1'b1;
                        end
                        default: begin
                            result_d   = rem_next[WIDTH-1:0];
                            dbz_d      = (b_q == '0);
                            done_mod_d = 1'b1;
                        end
                    endcase
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            kind_q     <= K_MUL;
            cnt_q      <= '0;
            prod_q     <= '0;
            mcand_q    <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            result_q   <= '0;
            done_mul_q <= 1'b0;
            done_div_q <= 1'b0;
            done_mod_q <= 1'b0;
            busy_q     <= 1'b0;
            mul_ovf_q  <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            cnt_q      <= cnt_d;
            prod_q     <= prod_d;
            mcand_q    <= mcand_d;
            b_q        <= b_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            result_q   <= result_d;
            done_mul_q <= done_mul_d;
            done_div_q <= done_div_d;
            done_mod_q <= done_mod_d;
            busy_q     <= busy_d;
            mul_ovf_q  <= mul_ovf_d;
            dbz_q      <= dbz_d;
        end
    end

    assign result      = result_q;
    assign done_mul    = done_mul_q;
    assign done_div    = done_div_q;
    assign done_mod    = done_mod_q;
    assign busy        = busy_q;
    assign mul_ovf     = mul_ovf_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Randomized self-checking bench for alu_seq_unit against an arithmetic reference model.
module tb_alu_seq_unit;

    localparam logic [4:0] OP_MUL = 5'd7;
    localparam logic [4:0] OP_DIV = 5'd2;
    localparam logic [4:0] OP_MOD = 5'd5;
`ifdef ALU_SEQ_DBZ_FAST_EN
    localparam bit FAST_DBZ = 1'b1;
`else
    localparam bit FAST_DBZ = 1'b0;
`endif

    logic        clk, rst, start;
    logic [4:0]  alu_op;
    logic [15:0] operand_a, operand_b, result;
    logic        done_mul, done_div, done_mod, busy, mul_ovf, div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq_unit dut (
        .clk(clk), .rst(rst), .start(start), .alu_op(alu_op),
        .operand_a(operand_a), .operand_b(operand_b), .result(result),
        .done_mul(done_mul), .done_div(done_div), .done_mod(done_mod),
        .busy(busy), .mul_ovf(mul_ovf), .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's definition.
    function automatic void model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] res, output logic ovf, output logic dbz,
                                  output logic [2:0] dones);
        logic [31:0] p;
        ovf = 1'b0; dbz = 1'b0;
        if (op == OP_MUL) begin
            p = 32'(a) * 32'(b);
            res = p[15:0];
            ovf = (p[31:16] != 16'h0);
            dones = 3'b100;
        end else if (op == OP_DIV) begin
            dbz = (b == 16'h0);
            res = dbz ? 16'hFFFF : a / b;
            dones = 3'b010;
        end else begin
            dbz = (b == 16'h0);
            res = dbz ? a : a % b;
            dones = 3'b001;
        end
    endfunction

    // Called at a negedge; returns at the negedge after the cycle that follows done.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [15:0] a,
                          input logic [15:0] b, input bit intrude);
        logic [15:0] e_res;
        logic        e_ovf, e_dbz;
        logic [2:0]  e_dones;
        int          lat, e_lat;
        bit          got;
        model(op, a, b, e_res, e_ovf, e_dbz, e_dones);
        e_lat = (FAST_DBZ && op != OP_MUL && b == 16'h0) ? 0 : 16;
        start = 1'b1; alu_op = op; operand_a = a; operand_b = b;
        @(posedge clk);
        #1 start = 1'b0;
        alu_op = 5'($urandom_range(0, 31));
        lat = 0; got = 1'b0;
        while (!got && lat <= 40) begin
            @(negedge clk);
            if (lat == 0) check({tag, "_busy_start"}, 32'(busy), 32'd1);
            if (done_mul | done_div | done_mod) begin
                got = 1'b1;
            end else begin
                if (intrude && lat == 4) begin
                    start = 1'b1; alu_op = OP_MUL;
                    operand_a = 16'($urandom); operand_b = 16'($urandom);
                end else begin
                    start = 1'b0;
                end
                lat++;
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(e_lat));
        if (!got) return;
        check({tag, "_dones"}, 32'({done_mul, done_div, done_mod}), 32'(e_dones));
        check({tag, "_result"}, 32'(result), 32'(e_res));
        check({tag, "_flags"}, 32'({mul_ovf, div_by_zero}), 32'({e_ovf, e_dbz}));
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, "_after"}, 32'({done_mul, done_div, done_mod, busy}), 32'd0);
    endtask

    initial begin
        logic [4:0]  rop;
        logic [15:0] ra, rb;
        bit          seen;
        rst = 1'b1; start = 1'b0; alu_op = 5'd0; operand_a = 16'h0; operand_b = 16'h0;
        #1;
        check("reset_outputs", 32'({result, done_mul, done_div, done_mod, busy, mul_ovf, div_by_zero}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("mul_basic", OP_MUL, 16'h0123, 16'h0045, 1'b0);
        run_op("mul_ovf", OP_MUL, 16'h1234, 16'h0100, 1'b0);
        repeat (10) @(negedge clk);
        check("mul_ovf_hold", 32'({result, mul_ovf}), 32'({16'h3400, 1'b1}));

        run_op("div_1000_7", OP_DIV, 16'd1000, 16'd7, 1'b0);
        run_op("mod_1000_7", OP_MOD, 16'd1000, 16'd7, 1'b0);
        run_op("div_zero", OP_DIV, 16'h0055, 16'h0000, 1'b0);
        run_op("mod_zero", OP_MOD, 16'h0055, 16'h0000, 1'b0);
        run_op("mul_after_dbz", OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0);

        start = 1'b1; alu_op = 5'd10; operand_a = 16'h1111; operand_b = 16'h2222;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen |= busy | done_mul | done_div | done_mod;
        end
        check("bad_op_ignored", 32'(seen), 32'd0);

        run_op("div_intrude", OP_DIV, 16'hBEEF, 16'h0013, 1'b1);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0: rop = OP_MUL;
                1: rop = OP_DIV;
                default: rop = OP_MOD;
            endcase
            ra = 16'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom >> $urandom_range(0, 15));
            run_op($sformatf("rand%0d", i), rop, ra, rb, 1'b0);
        end

        // Abort a multiply part-way through with an asynchronous reset.
        start = 1'b1; alu_op = OP_MUL; operand_a = 16'h1234; operand_b = 16'h5678;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async", 32'({result, busy, mul_ovf, div_by_zero, done_mul, done_div, done_mod}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen |= busy | done_mul | done_div | done_mod;
        end
        check("rst_no_done", 32'(seen), 32'd0);
        run_op("mul_after_rst", OP_MUL, 16'h0003, 16'h0004, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Iterative multi-cycle arithmetic engine for MUL, DIV and MOD.
- Responder side of the control unit's start/done handshake: accepts a one-cycle `start` with an opcode on `alu_op`, runs 16 iterations, then returns a one-cycle per-opcode done pulse.
- Operand A comes from the target register; operand B comes from the MDR.
- Its result drives the ALU result mux while the control unit writes it back.

Parameters:
- WIDTH, 16, operand/result width; iteration count equals WIDTH.
- OP_MUL, 5'd7, alu_op code for multiply.
- OP_DIV, 5'd2, alu_op code for divide (quotient).
- OP_MOD, 5'd5, alu_op code for modulo (remainder).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle request strobe from control unit
- alu_op  input  5  operation code, sampled with start
- operand_a  input  WIDTH  multiplicand / dividend
- operand_b  input  WIDTH  multiplier / divisor
- result  output  WIDTH  low product, quotient or remainder; held until next accepted start
- done_mul  output  1  one-cycle completion pulse, MUL
- done_div  output  1  one-cycle completion pulse, DIV
- done_mod  output  1  one-cycle completion pulse, MOD
- busy  output  1  high in RUN and DONE
- mul_ovf  output  1  high product half nonzero; valid with done_mul, held
- div_by_zero  output  1  divisor was zero; valid with done_div/done_mod, held

Behaviour:
- Reset (async): state=IDLE, iteration count=0. result, all done_*, busy, mul_ovf, div_by_zero = 0. Internal operand/accumulator registers are cleared.
- States and transitions:
  - IDLE -> RUN on a clk edge T where start=1 and alu_op is OP_MUL, OP_DIV or OP_MOD.
  - At edge T: latch operands and op; clear accumulator; count=0; clear mul_ovf and div_by_zero.
  - start with any other alu_op is ignored; state stays IDLE.
  - RUN: one iteration per edge, at T+1 through T+16. The edge completing count==WIDTH-1 moves state to DONE.
  - DONE: lasts exactly one cycle, between edges T+16 and T+17.
    - Exactly one done_* is high, selected by the latched op.
    - result, mul_ovf and div_by_zero are valid in this cycle.
    - Next edge returns to IDLE.
- Latency: done visible 16 cycles after the start-sampling edge. busy is high from edge T through the DONE cycle.
- start while busy is ignored; in-progress operation and latched operands are unaffected.
- MUL: unsigned shift-add, 2*WIDTH product accumulator, one multiplier bit per iteration (LSB first).
  - result = product[WIDTH-1:0].
  - mul_ovf = |product[2*WIDTH-1:WIDTH].
- DIV/MOD: unsigned restoring division, one quotient bit per iteration (MSB first).
  - Partial remainder is WIDTH+1 bits.
  - DIV result = quotient; MOD result = final remainder.
- Divide by zero (operand_b==0 latched, DIV or MOD):
  - div_by_zero=1.
  - DIV result=all ones (0xFFFF); MOD result=operand_a.
  - Timing is unchanged (16 iterations) unless the optional feature is enabled.
- result and flags update only on entry to DONE. They hold through IDLE until the next accepted start, so the control unit may sample them during the done cycle.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; no done pulse for the aborted op. A start on the first edge after rst deasserts is accepted normally.
- alu_op changes during RUN have no effect (latched copy used).

Optional Feature:
- Macro: ALU_SEQ_DBZ_FAST_EN.
- Defined: DIV/MOD with latched divisor 0 skips RUN. State goes IDLE->DONE at edge T; the done pulse is in the cycle between T and T+1, with the divide-by-zero result values above. busy is high only during that cycle.
- Not defined: divide by zero takes the full 16-iteration path with identical result values.
- MUL timing is unaffected either way.

Test Plan:
- MUL: a=0x0123, b=0x0045, start at edge T -> done_mul only, high between T+16 and T+17; result=0x4E6F; mul_ovf=0; busy drops at T+17.
- MUL overflow: a=0x1234, b=0x0100 -> result=0x3400, mul_ovf=1; result still 0x3400 ten cycles later.
- DIV then MOD: a=1000 (0x03E8), b=7.
  - DIV -> done_div pulse, result=0x008E.
  - Back-to-back MOD start in the idle cycle after -> done_mod, result=0x0006.
- Divide by zero: DIV a=0x0055, b=0 -> result=0xFFFF, div_by_zero=1; MOD a=0x0055, b=0 -> result=0x0055, div_by_zero=1.
  - Done at T+16 without the macro; at T with ALU_SEQ_DBZ_FAST_EN.
- Protocol: start with alu_op=5'd10 -> no busy, no done. A second start (MUL, new operands) at T+5 during DIV -> ignored; DIV result is correct and only done_div pulses.
- Reset: rst pulse asynchronously at T+8 of a MUL -> busy=0, result=0 immediately; no done pulse. Restart MUL 0x0003*0x0004 -> result=0x000C after 16 cycles.
